// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module   : alu_arbiter
// Purpose  : Round-robin arbiter sharing one ALU between two requesters.
//            One operation is in flight at a time. An accepted operation is
//            executed (one cycle, or MUL_CYCLES cycles for MUL). Its result
//            is then returned through a registered response channel, tagged
//            with the owning requester's index.
//
// Ports    : clk, rst_n                  clock, synchronous active-low reset
//            req_valid[1:0]/req_ready    per-requester request handshake
//            req{0,1}_num_1/_num_2/_op   per-requester operands and opcode
//            res_valid/res_ready         response handshake
//            res_data[2*WIDTH-1:0]       registered ALU result
//            res_id                      requester that owns the result
//            res_err                     illegal-opcode flag
//            busy                        operation in EXEC or DONE
//
// Opcodes  : 0 ADD, 1 SUBTR, 2 MUL, 3 ARTH_SHIFT_R, 4 SHIFT_L, 5 SHIFT_R.
//            Opcodes 6 and 7 return zero.
//
// Config   : `define ALU_ARBITER_ERR_EN makes opcodes 6/7 raise res_err.
//            When it is undefined, res_err is tied to 0.
//            WIDTH must be 2 or more.
//
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req0_num_1,
  input  logic [WIDTH-1:0]   req0_num_2,
  input  logic [2:0]         req0_op,
  input  logic [WIDTH-1:0]   req1_num_1,
  input  logic [WIDTH-1:0]   req1_num_2,
  input  logic [2:0]         req1_op,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_id,
  output logic               res_err,
  output logic               busy
);

  localparam int RES_W = 2 * WIDTH;
  // The counter only needs to hold MUL_CYCLES-1.
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_exec = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [2:0] c_op_add = 3'd0;
  localparam logic [2:0] c_op_sub = 3'd1;
  localparam logic [2:0] c_op_mul = 3'd2;
  localparam logic [2:0] c_op_asr = 3'd3;
  localparam logic [2:0] c_op_shl = 3'd4;
  localparam logic [2:0] c_op_shr = 3'd5;

  localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_CYCLES - 1);
  localparam logic [RES_W-1:0] c_res_w    = RES_W'(RES_W);

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_num_1;
  logic [WIDTH-1:0] r_num_2;
  logic [2:0]       r_op;
  logic             r_id;
  logic             r_res_valid;
  logic [RES_W-1:0] r_res_data;
  logic             r_res_id;
  logic             r_res_err;

  logic             w_grant;
  logic [1:0]       w_ready;
  logic             w_accept;
  logic [RES_W-1:0] w_a;
  logic [RES_W-1:0] w_b;
  logic             w_shift_oor;
  logic [RES_W-1:0] w_alu;
  logic             w_err;

  //--------------------------------------------------------------------------
  // Arbitration. A lone requester always wins. On a tie, the requester that
  // did not win last time wins.
  //--------------------------------------------------------------------------
  always_comb begin
    w_grant = 1'b0;
    w_ready = 2'b00;
    if (req_valid == 2'b11) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req_valid[1];
    end
    if (r_state == c_st_idle) begin
      w_ready[w_grant] = req_valid[w_grant];
    end
  end

  assign w_accept = |(req_valid & w_ready);

  //--------------------------------------------------------------------------
  // ALU on the latched operands. The operands are zero-extended, so the
  // arithmetic right shift is the same as a logical right shift.
  //--------------------------------------------------------------------------
  assign w_a         = {{WIDTH{1'b0}}, r_num_1};
  assign w_b         = {{WIDTH{1'b0}}, r_num_2};
  assign w_shift_oor = (w_b >= c_res_w);

  always_comb begin
    w_alu = '0;
    case (r_op)
      c_op_add: w_alu = w_a + w_b;
      c_op_sub: w_alu = w_a - w_b;
      c_op_mul: w_alu = w_a * w_b;
      c_op_asr: w_alu = w_shift_oor ? '0 : (w_a >> r_num_2);
      c_op_shl: w_alu = w_shift_oor ? '0 : (w_a << r_num_2);
      c_op_shr: w_alu = w_shift_oor ? '0 : (w_a >> r_num_2);
      default:  w_alu = '0;
    endcase
  end

`ifdef ALU_ARBITER_ERR_EN
  assign w_err = r_op[2] & r_op[1];
`else
  assign w_err = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // Control FSM and response registers.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_st_idle;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_num_1      <= '0;
      r_num_2      <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_id     <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_num_1      <= w_grant ? req1_num_1 : req0_num_1;
            r_num_2      <= w_grant ? req1_num_2 : req0_num_2;
            r_op         <= w_grant ? req1_op    : req0_op;
            r_cnt        <= ((w_grant ? req1_op : req0_op) == c_op_mul) ? c_mul_load : '0;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= c_st_exec;
          end
        end
        c_st_exec: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_res_data  <= w_alu;
            r_res_id    <= r_id;
            r_res_err   <= w_err;
            r_res_valid <= 1'b1;
            r_state     <= c_st_done;
          end
        end
        c_st_done: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= c_st_idle;
          end
        end
        default: begin
          r_state     <= c_st_idle;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_err   = r_res_err;
  assign busy      = (r_state != c_st_idle);

endmodule

`default_nettype wire
